iq_capture_buffer: RTL
======================

// Module: iq_capture_buffer
// PURPOSE
//  Snapshot buffer for decimated baseband I/Q. Sits downstream of the downsampler filter pair and taps
//  downsampled_x/y, qualified by the down-path ce_out. It stores a triggered burst in block RAM.
//  The LiteX CSR bank then reads the burst back one word at a time for host-side spectrum and EVM analysis.
// PARAMETERS
//  DW     16    sample width of each of I and Q (signed)
//  AW     10    address width; DEPTH = 2**AW words of {Q,I}
// PORTS
//  sys_clk      in   1      single clock for all logic
//  rst_n        in   1      synchronous, active-low reset
//  s_valid      in   1      sample strobe (downsampler ce_out)
//  s_x          in   DW     I sample, signed, valid with s_valid
//  s_y          in   DW     Q sample, signed, valid with s_valid
//  arm          in   1      1-cycle pulse: start new capture
//  abort        in   1      1-cycle pulse: return to IDLE
//  trig_mode    in   1      0 = immediate, 1 = rising crossing of s_x through trig_level
//  trig_level   in   DW     signed threshold
//  num_samples  in   AW+1   burst length; 0 or >DEPTH -> DEPTH
//  rd_en        in   1      CSR read strobe, 1-cycle pulse
//  rd_data      out  2*DW   {Q,I} of word at read pointer
//  rd_valid     out  1      1-cycle pulse, rd_data updated
//  state        out  2      0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 DONE
//  count        out  AW+1   words stored in current burst
//  rd_err       out  1      sticky: rd_en outside DONE or past count; cleared by arm
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=IDLE; count, pointers, rd_data, rd_valid, rd_err = 0. RAM contents not reset.
//  - IDLE/DONE + arm: wr_ptr=rd_ptr=count=0, rd_err=0, prev-sample flag cleared.
//    trig_mode=0 -> CAPTURE; trig_mode=1 -> WAIT_TRIG. Both take effect at the next edge.
//  - arm while in WAIT_TRIG or CAPTURE: ignored.
//  - abort: any state -> IDLE at next edge. abort wins over arm in the same cycle. count is kept for debug.
//  - WAIT_TRIG: on each s_valid compare s_x with the previous valid s_x (signed).
//    Trigger when prev < trig_level and s_x >= trig_level.
//    The first valid sample after arm only seeds prev and can never trigger.
//    The triggering sample is written as word 0, and state -> CAPTURE with count=1.
//  - CAPTURE: each s_valid writes {s_y,s_x} to RAM[wr_ptr], wr_ptr++, count++ at the same edge.
//    When count reaches the effective length (limit), state -> DONE at that same edge.
//    No write happens without s_valid. Samples arriving in DONE/IDLE are dropped.
//  - limit is latched at arm. Changing num_samples mid-burst has no effect.
//  - DONE + rd_en with rd_ptr<count: rd_data=RAM[rd_ptr] and rd_valid=1 one cycle after rd_en; rd_ptr++.
//    rd_ptr reaching count stays there; further rd_en sets rd_err, rd_data holds, no rd_valid.
//  - rd_en in any state other than DONE: sets rd_err, no other effect.
//  - rd_valid is a single-cycle pulse. Back-to-back rd_en gives back-to-back rd_valid.
//  - Capture latency: s_valid at edge n -> word visible to readback from edge n+1.
//    state=DONE is visible in the cycle after the last write edge.
//  - RAM is a simple dual-port, 1 write + 1 registered read, inferred as BRAM.
// CONFIGURATION
//  - IQ_CAPTURE_DECIM_EN defined: adds port decim_m (in, 8, keep 1 of decim_m+1 valid samples).
//    A sample counter, cleared at arm, qualifies s_valid before both the trigger and capture logic.
//    decim_m is latched at arm. The trigger sample itself counts as kept.
//  - IQ_CAPTURE_DECIM_EN undefined: no decim_m port; every s_valid sample is used.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles with arm=1 -> state=0, count=0, rd_valid=0, rd_err=0.
//  2 Immediate: num_samples=8, trig_mode=0, arm, then drive s_x=k, s_y=-k for k=1..12 with s_valid every 4th cycle
//    -> DONE after the 8th strobe, count=8. Eight rd_en give {-k,k} for k=1..8; the 9th rd_en sets rd_err.
//  3 Trigger: trig_mode=1, trig_level=100, s_x sequence 50,90,99,100,120 -> word 0 has I=100, count increments from there.
//    Sequence starting 150,200 -> no trigger (no crossing).
//  4 Limit/wrap: num_samples=0 and AW=4 -> 16 words captured, state=DONE, count=16. No overwrite of word 0.
//  5 Abort/arm: arm+abort in the same cycle -> IDLE. abort mid-CAPTURE at count=3 -> IDLE, count=3, later strobes ignored.
//    Re-arm -> count=0, rd_err=0.
//  6 With IQ_CAPTURE_DECIM_EN, decim_m=2, immediate, num_samples=4, s_x=0..11 -> stored I = 0,3,6,9.

Source files
------------

// File: rtl/iq_capture_buffer_if.sv
// iq_capture_buffer_if: sample stream, capture control and CSR readback
// signals of the I/Q snapshot buffer, grouped so that the buffer can
// take them as a single port.
// Optional IQ_CAPTURE_DECIM_EN adds the decim_m control field.
interface iq_capture_buffer_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic                 s_valid;
    logic [DW-1:0]        s_x;
    logic [DW-1:0]        s_y;
    logic                 arm;
    logic                 abort;
    logic                 trig_mode;
    logic [DW-1:0]        trig_level;
    logic [AW:0]          num_samples;
    logic                 rd_en;
    logic [2*DW-1:0]      rd_data;
    logic                 rd_valid;
    logic [1:0]           state;
    logic [AW:0]          count;
    logic                 rd_err;
`ifdef IQ_CAPTURE_DECIM_EN
    logic [7:0]           decim_m;

    modport master (
        output s_valid, s_x, s_y, arm, abort, trig_mode, trig_level,
               num_samples, rd_en, decim_m,
        input  rd_data, rd_valid, state, count, rd_err
    );
    modport slave (
        input  s_valid, s_x, s_y, arm, abort, trig_mode, trig_level,
               num_samples, rd_en, decim_m,
        output rd_data, rd_valid, state, count, rd_err
    );
`else
    modport master (
        output s_valid, s_x, s_y, arm, abort, trig_mode, trig_level,
               num_samples, rd_en,
        input  rd_data, rd_valid, state, count, rd_err
    );
    modport slave (
        input  s_valid, s_x, s_y, arm, abort, trig_mode, trig_level,
               num_samples, rd_en,
        output rd_data, rd_valid, state, count, rd_err
    );
`endif
endinterface

// File: rtl/iq_capture_buffer.sv
// iq_capture_buffer: triggered snapshot of decimated baseband I/Q into a
// simple dual-port block RAM. A burst is armed, optionally waits for a
// rising crossing of I through trig_level, fills up to the latched limit
// and is then read back one {Q,I} word per rd_en pulse.
// Optional feature: define IQ_CAPTURE_DECIM_EN to add bus.decim_m, which
// keeps 1 of every decim_m+1 valid samples (counter cleared at arm).
module iq_capture_buffer #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    iq_capture_buffer_if.slave bus
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                 state_q;
    logic [AW:0]            count_q;
    logic [AW:0]            limit_q;
    logic [AW-1:0]          wr_ptr_q;
    logic [AW:0]            rd_ptr_q;
    logic                   prev_vld_q;
    logic signed [DW-1:0]   prev_x_q;
    logic [2*DW-1:0]        rd_data_q;
    logic                   rd_valid_q;
    logic                   rd_err_q;

    logic [2*DW-1:0]        mem [DEPTH];

`ifdef IQ_CAPTURE_DECIM_EN
    logic [7:0]             decim_q;
    logic [7:0]             dcnt_q;
`endif

    logic                   arm_go;
    logic                   samp;
    logic                   trig_hit;
    logic                   wr_en;
    logic                   rd_ok;
    logic                   rd_bad;
    logic [AW:0]            limit_d;
    logic [AW:0]            count_inc;

    // Qualify samples, detect the trigger crossing and decode read requests
    always_comb begin
        arm_go    = bus.arm && !bus.abort && (state_q == IDLE || state_q == DONE);
        limit_d   = (bus.num_samples == '0 || bus.num_samples > DEPTH_W) ? DEPTH_W : bus.num_samples;
`ifdef IQ_CAPTURE_DECIM_EN
        samp      = bus.s_valid && (dcnt_q == 8'd0);
`else
        samp      = bus.s_valid;
`endif
        // A crossing needs a seeded previous sample, so the first sample after arm never fires
        trig_hit  = samp && prev_vld_q &&
                    (prev_x_q < $signed(bus.trig_level)) &&
                    ($signed(bus.s_x) >= $signed(bus.trig_level));
        wr_en     = !bus.abort &&
                    ((state_q == CAPTURE && samp) || (state_q == WAIT_TRIG && trig_hit));
        count_inc = count_q + 1'b1;
        // A read in the same cycle as a re-arm is dropped; the arm resets the pointer
        rd_ok     = bus.rd_en && state_q == DONE && rd_ptr_q < count_q && !arm_go;
        rd_bad    = bus.rd_en && !(state_q == DONE && rd_ptr_q < count_q);
    end

    // Capture FSM: arm, trigger search, fill to limit; abort always wins
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            limit_q    <= DEPTH_W;
            wr_ptr_q   <= '0;
            prev_vld_q <= 1'b0;
            prev_x_q   <= '0;
`ifdef IQ_CAPTURE_DECIM_EN
            decim_q    <= '0;
            dcnt_q     <= '0;
`endif
        end else if (bus.abort) begin
            state_q    <= IDLE;
        end else begin
`ifdef IQ_CAPTURE_DECIM_EN
            if (arm_go) begin
                decim_q <= bus.decim_m;
                dcnt_q  <= '0;
            end else if (bus.s_valid && (state_q == WAIT_TRIG || state_q == CAPTURE)) begin
                dcnt_q  <= (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
            end
`endif
            case (state_q)
                IDLE, DONE: begin
                    if (arm_go) begin
                        wr_ptr_q   <= '0;
                        count_q    <= '0;
                        prev_vld_q <= 1'b0;
                        limit_q    <= limit_d;
                        state_q    <= bus.trig_mode ? WAIT_TRIG : CAPTURE;
                    end
                end
                WAIT_TRIG: begin
                    if (samp) begin
                        prev_x_q   <= $signed(bus.s_x);
                        prev_vld_q <= 1'b1;
                        if (trig_hit) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            count_q  <= count_inc;
                            state_q  <= (count_inc >= limit_q) ? DONE : CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    if (samp) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        count_q  <= count_inc;
                        if (count_inc == limit_q)
                            state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sample RAM write port (contents are not reset)
    always_ff @(posedge sys_clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= {bus.s_y, bus.s_x};
    end

    // Registered readback port, read pointer and sticky read error
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_ok;
            if (rd_ok) begin
                rd_data_q <= mem[rd_ptr_q[AW-1:0]];
                rd_ptr_q  <= rd_ptr_q + 1'b1;
            end
            if (arm_go) begin
                rd_ptr_q <= '0;
                rd_err_q <= 1'b0;
            end else if (rd_bad) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.rd_err   = rd_err_q;

endmodule
